// File: rtl/pmem_responder_if.sv
// Load/store bus between the CPU (master) and the memory responder (slave):
// a request channel and a response channel, each with its own valid/ready handshake.
interface pmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/pmem_responder.sv
// Stalling memory model for the CPU load/store port: takes one request at a time,
// waits LATENCY cycles, then serves it from an internal word array.
module pmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [3:0]  r_count;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_access;
    logic             w_resp_done;
    logic             w_err;
    logic [31:0]      w_offset;
    logic [31:0]      w_index;
    logic [IDX_W-1:0] w_idx;

    // Unsigned wrap of the subtraction makes low addresses look huge, but they are
    // still rejected explicitly by the addr < BASE_ADDR term.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_index  = w_offset >> 2;
    assign w_idx    = w_index[IDX_W-1:0];
    assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR)
                   || (w_index >= 32'(DEPTH_WORDS));

    // The first edge spent in S_RESP with no response pending is the access edge.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = (LAT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == 4'd1) w_next_state = S_RESP;
            end
            S_RESP: begin
                if (!r_resp_valid) begin
                    w_access = 1'b1;
                end else if (bus.resp_ready) begin
                    w_resp_done  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_count      <= 4'd0;
            r_wen        <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_wmask      <= 4'h0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == S_IDLE);
            if (w_accept) begin
                r_wen   <= bus.req_wen;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
                r_count <= LAT;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - 4'd1;
            end
            if (w_access) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (!r_wen && !w_err) ? r_mem[w_idx] : 32'h0;
            end else if (w_resp_done) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= 32'h0;
            end
        end
    end

    // Array has no reset; a reset before the access edge leaves r_state idle, so no write.
    always_ff @(posedge i_clk) begin
        if (w_access && r_wen && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule
